// File: rtl/sdram_pkg.sv
// Shared SDRAM controller definitions: command encodings,
// auto-refresh scheduler states and the debt width helper.
package sdram_pkg;

    localparam logic [3:0] NOP      = 4'b0111;
    localparam logic [3:0] P_CHARGE = 4'b0010;
    localparam logic [3:0] A_REF    = 4'b0001;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PCHA,
        S_TRP,
        S_AREF,
        S_TRC,
        S_END
    } aref_state_t;

    function automatic int debt_w(input int max_debt);
        return (max_debt < 1) ? 1 : $clog2(max_debt + 1);
    endfunction

endpackage

// File: rtl/sdram_ref_tick.sv
// Refresh interval timer, debt counter, overflow flag and urgency compare.
// AREF_POSTPONE_EN enables the full debt counter; otherwise debt is a flag.
module sdram_ref_tick
    import sdram_pkg::*;
#(
    parameter int REF_INTERVAL = 1248,
    parameter int MAX_DEBT     = 8,
    parameter int URGENT_DEBT  = 6,
    parameter int DW           = debt_w(MAX_DEBT)
) (
    input  logic          sys_clk,
    input  logic          sys_rst,
    input  logic          init_end,
    input  logic          idle,
    input  logic          dec,
    output logic          tick,
    output logic          urgent,
    output logic          ovf,
    output logic [DW-1:0] debt
);

`ifdef AREF_POSTPONE_EN
    localparam bit POSTPONE = 1'b1;
`else
    localparam bit POSTPONE = 1'b0;
`endif

    localparam int EFF_MAX = POSTPONE ? MAX_DEBT : 1;
    localparam int URG_THR = POSTPONE ? URGENT_DEBT : 1;
    localparam int TW      = $clog2(REF_INTERVAL + 1);

    logic [TW-1:0] timer;
    logic          full;

    assign tick   = init_end && (timer == TW'(REF_INTERVAL - 1));
    assign full   = (debt == DW'(EFF_MAX));
    // Without postponement urgency collapses onto the plain request.
    assign urgent = (debt >= DW'(URG_THR)) && (POSTPONE || idle);

    always_ff @(posedge sys_clk) begin
        if (sys_rst || !init_end) begin
            timer <= '0;
        end else if (tick) begin
            timer <= '0;
        end else begin
            timer <= timer + TW'(1);
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            debt <= '0;
            ovf  <= 1'b0;
        end else begin
            if (tick && full) begin
                ovf <= 1'b1;
            end
            if (tick && !dec && !full) begin
                debt <= debt + DW'(1);
            end else if (dec && !tick) begin
                debt <= debt - DW'(1);
            end
        end
    end

endmodule

// File: rtl/sdram_aref_sched.sv
// Auto-refresh scheduler: PRECHARGE-ALL then bursts of AUTO REFRESH until
// the refresh debt drains. Optional AREF_POSTPONE_EN enables debt > 1.
module sdram_aref_sched
    import sdram_pkg::*;
#(
    parameter int REF_INTERVAL = 1248,
    parameter int TRP_CLK      = 2,
    parameter int TRC_CLK      = 6,
    parameter int BURST_REF    = 2,
    parameter int MAX_DEBT     = 8,
    parameter int URGENT_DEBT  = 6,
    parameter int ADDR_W       = 13,
    parameter int BA_W         = 2
) (
    input  logic                        sys_clk,
    input  logic                        sys_rst,
    input  logic                        init_end,
    input  logic                        aref_en,
    output logic                        aref_req,
    output logic                        aref_urgent,
    output logic [3:0]                  aref_cmd,
    output logic [BA_W-1:0]             aref_ba,
    output logic [ADDR_W-1:0]           aref_addr,
    output logic                        aref_end,
    output logic                        aref_busy,
    output logic [debt_w(MAX_DEBT)-1:0] aref_debt,
    output logic                        aref_ovf
);

    localparam int DW   = debt_w(MAX_DEBT);
    localparam int WMAX = (TRP_CLK > TRC_CLK) ? TRP_CLK : TRC_CLK;
    localparam int WW   = $clog2(WMAX + 1);
    localparam int RW   = $clog2(BURST_REF + 1);

    aref_state_t   state;
    logic [WW-1:0] wait_cnt;
    logic [RW-1:0] ref_cnt;
    logic          tick;
    logic          trp_done;
    logic          trc_done;
    logic          burst_last;
    logic          grp_done;
    logic          last_grp;

    assign trp_done   = (wait_cnt == WW'(TRP_CLK - 1));
    assign trc_done   = (wait_cnt == WW'(TRC_CLK - 1));
    assign burst_last = (ref_cnt == RW'(BURST_REF - 1));
    assign grp_done   = (state == S_TRC) && trc_done && burst_last;
    // A tick landing on the final decrement keeps the service going.
    assign last_grp   = (aref_debt == DW'(1)) && !tick;

    assign aref_req  = (state == S_IDLE) && (aref_debt != '0);
    assign aref_busy = (state != S_IDLE);
    assign aref_end  = (state == S_END);

    sdram_ref_tick #(
        .REF_INTERVAL(REF_INTERVAL),
        .MAX_DEBT    (MAX_DEBT),
        .URGENT_DEBT (URGENT_DEBT),
        .DW          (DW)
    ) u_tick (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .init_end(init_end),
        .idle    (state == S_IDLE),
        .dec     (grp_done),
        .tick    (tick),
        .urgent  (aref_urgent),
        .ovf     (aref_ovf),
        .debt    (aref_debt)
    );

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state     <= S_IDLE;
            wait_cnt  <= '0;
            ref_cnt   <= '0;
            aref_cmd  <= NOP;
            aref_ba   <= '1;
            aref_addr <= '1;
        end else begin
            aref_ba   <= '1;
            aref_addr <= '1;
            wait_cnt  <= '0;
            unique case (state)
                S_IDLE: begin
                    aref_cmd <= NOP;
                    if (aref_en && init_end && aref_debt != '0)
                        state <= S_PCHA;
                end
                S_PCHA: begin
                    aref_cmd <= P_CHARGE;
                    state    <= S_TRP;
                end
                S_TRP: begin
                    aref_cmd <= NOP;
                    if (trp_done) state <= S_AREF;
                    else wait_cnt <= wait_cnt + WW'(1);
                end
                S_AREF: begin
                    aref_cmd <= A_REF;
                    state    <= S_TRC;
                end
                S_TRC: begin
                    aref_cmd <= NOP;
                    if (!trc_done) begin
                        wait_cnt <= wait_cnt + WW'(1);
                    end else if (!burst_last) begin
                        ref_cnt <= ref_cnt + RW'(1);
                        state   <= S_AREF;
                    end else begin
                        ref_cnt <= '0;
                        state   <= last_grp ? S_END : S_AREF;
                    end
                end
                S_END: begin
                    aref_cmd <= NOP;
                    state    <= S_IDLE;
                end
                default: begin
                    aref_cmd <= NOP;
                    state    <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_aref_sched.sv
// Bench for sdram_aref_sched: queue-based command schedule model compared
// every cycle, plus directed scenarios with literal expectations.
module tb_sdram_aref_sched;

    localparam int REF_INTERVAL = 1248;
    localparam int TRP_CLK      = 2;
    localparam int TRC_CLK      = 6;
    localparam int BURST_REF    = 2;
    localparam int MAX_DEBT     = 8;
    localparam int URGENT_DEBT  = 6;
    localparam int ADDR_W       = 13;
    localparam int BA_W         = 2;
    localparam int DW           = $clog2(MAX_DEBT + 1);

`ifdef AREF_POSTPONE_EN
    localparam bit POSTPONE = 1'b1;
    localparam int MAXE     = MAX_DEBT;
`else
    localparam bit POSTPONE = 1'b0;
    localparam int MAXE     = 1;
`endif

    localparam logic [3:0] C_NOP = 4'b0111;
    localparam logic [3:0] C_PRE = 4'b0010;
    localparam logic [3:0] C_REF = 4'b0001;

    logic clk = 1'b0;
    logic sys_rst = 1'b1;
    logic init_end = 1'b0;
    logic aref_en = 1'b0;
    logic aref_req, aref_urgent, aref_end, aref_busy, aref_ovf;
    logic [3:0] aref_cmd;
    logic [BA_W-1:0] aref_ba;
    logic [ADDR_W-1:0] aref_addr;
    logic [DW-1:0] aref_debt;

    always #5 clk = ~clk;

    sdram_aref_sched #(
        .REF_INTERVAL(REF_INTERVAL), .TRP_CLK(TRP_CLK), .TRC_CLK(TRC_CLK),
        .BURST_REF(BURST_REF), .MAX_DEBT(MAX_DEBT), .URGENT_DEBT(URGENT_DEBT),
        .ADDR_W(ADDR_W), .BA_W(BA_W)
    ) dut (
        .sys_clk(clk), .sys_rst(sys_rst), .init_end(init_end),
        .aref_en(aref_en), .aref_req(aref_req), .aref_urgent(aref_urgent),
        .aref_cmd(aref_cmd), .aref_ba(aref_ba), .aref_addr(aref_addr),
        .aref_end(aref_end), .aref_busy(aref_busy), .aref_debt(aref_debt),
        .aref_ovf(aref_ovf)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Model: a service is a queue of expected commands; groups are appended
    // while debt remains when the previous group's last tRC slot is reached.
    typedef struct {
        logic [3:0] cmd;
        bit         last;
    } item_t;

    item_t q[$];
    int    m_timer = 0;
    int    m_debt = 0;
    bit    m_ovf = 0;
    bit    m_busy = 0;
    bit    m_end = 0;
    logic [3:0] m_cmd = C_NOP;

    function automatic void push_group();
        for (int b = 0; b < BURST_REF; b++) begin
            q.push_back('{C_REF, 1'b0});
            for (int t = 0; t < TRC_CLK; t++)
                q.push_back('{C_NOP, (b == BURST_REF - 1) && (t == TRC_CLK - 1)});
        end
    endfunction

    task automatic model_step();
        bit tk, grant, dec;
        item_t it;
        if (sys_rst) begin
            m_timer = 0; m_debt = 0; m_ovf = 0;
            m_busy = 0; m_end = 0; m_cmd = C_NOP;
            q.delete();
        end else begin
            tk = init_end && (m_timer == REF_INTERVAL - 1);
            grant = !m_busy && aref_en && init_end && (m_debt != 0);
            dec = 0; m_end = 0; m_cmd = C_NOP;
            if (q.size() != 0) begin
                it = q.pop_front();
                m_cmd = it.cmd;
                dec = it.last;
            end
            if (tk && m_debt == MAXE) m_ovf = 1;
            if (tk && !dec && m_debt < MAXE) m_debt++;
            else if (dec && !tk) m_debt--;
            if (dec) begin
                if (m_debt != 0) push_group();
                else m_end = 1;
            end
            if (grant) begin
                q.push_back('{C_PRE, 1'b0});
                for (int t = 0; t < TRP_CLK; t++) q.push_back('{C_NOP, 1'b0});
                push_group();
            end
            m_busy = (q.size() != 0) || m_end;
            m_timer = init_end ? (m_timer + 1) % REF_INTERVAL : 0;
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    int cyc = 0;
    int n_pre = 0, n_ref = 0, n_end = 0, n_req = 0;
    int t_pre = -1;
    int c0 = 0;

    initial forever begin
        logic [27:0] act, exp;
        bit exp_req, exp_urg;
        @(negedge clk);
        cyc++;
        exp_req = !m_busy && (m_debt != 0);
        exp_urg = POSTPONE ? (m_debt >= URGENT_DEBT) : exp_req;
        exp = {m_cmd, {BA_W{1'b1}}, {ADDR_W{1'b1}}, exp_req, exp_urg,
               m_end, m_busy, DW'(m_debt), m_ovf};
        act = {aref_cmd, aref_ba, aref_addr, aref_req, aref_urgent,
               aref_end, aref_busy, aref_debt, aref_ovf};
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures < 20)
                $display("FAIL cycle_cmp cyc=%0d actual=%h expected=%h", cyc, act, exp);
        end
        if (aref_cmd == C_PRE) begin
            n_pre++;
            if (t_pre < 0) t_pre = cyc - c0;
        end
        if (aref_cmd == C_REF) n_ref++;
        if (aref_end) n_end++;
        if (aref_req) n_req++;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic clr();
        n_pre = 0; n_ref = 0; n_end = 0; n_req = 0;
        t_pre = -1; c0 = cyc;
    endtask

    task automatic do_reset();
        sys_rst = 1'b1;
        aref_en = 1'b0;
        step(2);
        sys_rst = 1'b0;
    endtask

    task automatic wait_end(input int budget, input string name);
        int start = n_end;
        int k = 0;
        while (n_end == start && k < budget) begin
            step(1);
            k++;
        end
        check(name, 32'(n_end != start), 32'd1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        step(2);
        check("rst_cmd", 32'(aref_cmd), 32'h7);
        check("rst_debt", 32'(aref_debt), 32'd0);
        check("rst_busy", 32'(aref_busy), 32'd0);
        check("rst_req", 32'(aref_req), 32'd0);
        check("rst_addr", 32'(aref_addr), 32'h1fff);

        // Grant tied high: one service per interval tick.
        do_reset();
        init_end = 1'b1;
        aref_en = 1'b1;
        clr();
        wait_end(1400, "s1_end_seen");
        step(2);
        aref_en = 1'b0;
        check("s1_pre_time", 32'(t_pre), 32'd1250);
        check("s1_pre", 32'(n_pre), 32'd1);
        check("s1_ref", 32'(n_ref), 32'd2);
        check("s1_endcnt", 32'(n_end), 32'd1);
        check("s1_debt", 32'(aref_debt), 32'd0);

`ifdef AREF_POSTPONE_EN
        do_reset();
        init_end = 1'b1;
        step(5 * REF_INTERVAL + 3);
        check("p6_debt5", 32'(aref_debt), 32'd5);
        check("p6_urg5", 32'(aref_urgent), 32'd0);
        step(REF_INTERVAL);
        check("p6_debt6", 32'(aref_debt), 32'd6);
        check("p6_urg6", 32'(aref_urgent), 32'd1);
        clr();
        aref_en = 1'b1;
        wait_end(200, "p6_end_seen");
        aref_en = 1'b0;
        step(2);
        check("p6_ref", 32'(n_ref), 32'd12);
        check("p6_pre", 32'(n_pre), 32'd1);
        check("p6_debt0", 32'(aref_debt), 32'd0);

        do_reset();
        init_end = 1'b1;
        step(8 * REF_INTERVAL + 3);
        check("p9_debt8", 32'(aref_debt), 32'd8);
        check("p9_ovf0", 32'(aref_ovf), 32'd0);
        step(REF_INTERVAL);
        check("p9_sat", 32'(aref_debt), 32'd8);
        check("p9_ovf1", 32'(aref_ovf), 32'd1);
        clr();
        aref_en = 1'b1;
        wait_end(300, "p9_end_seen");
        aref_en = 1'b0;
        step(2);
        check("p9_ref", 32'(n_ref), 32'd16);
        check("p9_debt0", 32'(aref_debt), 32'd0);
        check("p9_ovf_sticky", 32'(aref_ovf), 32'd1);
`else
        do_reset();
        init_end = 1'b1;
        step(2 * REF_INTERVAL + 3);
        check("np_debt", 32'(aref_debt), 32'd1);
        check("np_ovf", 32'(aref_ovf), 32'd1);
        check("np_req", 32'(aref_req), 32'd1);
        check("np_urg", 32'(aref_urgent), 32'd1);
        check("np_urg_eq_req", 32'(aref_urgent), 32'(aref_req));
`endif

        // Grant timed so the interval tick lands on the first group decrement.
        do_reset();
        init_end = 1'b1;
        step(REF_INTERVAL + 3);
        begin
            int k = 0;
            while (m_timer != REF_INTERVAL - 18 && k < REF_INTERVAL + 10) begin
                step(1);
                k++;
            end
        end
        check("co_debt1", 32'(aref_debt), 32'd1);
        clr();
        aref_en = 1'b1;
        step(1);
        aref_en = 1'b0;
        wait_end(100, "co_end_seen");
        step(2);
        check("co_ref", 32'(n_ref), 32'd4);
        check("co_pre", 32'(n_pre), 32'd1);
        check("co_debt0", 32'(aref_debt), 32'd0);
        check("co_ovf", 32'(aref_ovf), POSTPONE ? 32'd0 : 32'd1);

        // Reset while waiting out tRC, then a normal restart.
        do_reset();
        init_end = 1'b1;
        aref_en = 1'b1;
        begin
            int k = 0;
            while (m_cmd != C_REF && k < 1400) begin
                step(1);
                k++;
            end
        end
        step(2);
        check("rt_busy_pre", 32'(aref_busy), 32'd1);
        sys_rst = 1'b1;
        step(1);
        check("rt_cmd", 32'(aref_cmd), 32'h7);
        check("rt_debt", 32'(aref_debt), 32'd0);
        check("rt_busy", 32'(aref_busy), 32'd0);
        sys_rst = 1'b0;
        clr();
        wait_end(1400, "rt_restart_end");
        step(2);
        check("rt_pre", 32'(n_pre), 32'd1);
        check("rt_ref", 32'(n_ref), 32'd2);
        aref_en = 1'b0;

        // No refresh requests before initialisation completes.
        do_reset();
        init_end = 1'b0;
        aref_en = 1'b1;
        clr();
        step(2 * REF_INTERVAL + 10);
        check("ni_req", 32'(n_req), 32'd0);
        check("ni_pre", 32'(n_pre), 32'd0);
        check("ni_debt", 32'(aref_debt), 32'd0);
        aref_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sdram_aref_sched.md
# sdram_aref_sched

Parametrised auto-refresh scheduler for the SDRAM controller: a programmable interval timer with a refresh-debt counter. It requests service from the controller arbiter and, once granted, drives a PRECHARGE-ALL followed by a configurable burst of AUTO REFRESH commands onto the shared command mux. It supports postponed refreshes and an urgency flag so the arbiter can defer refresh behind read/write bursts without losing refresh cycles.

## Interface
- REF_INTERVAL, 1248: cycles between refresh ticks (7.5 us at 166 MHz)
- TRP_CLK, 2: NOP cycles after PRECHARGE
- TRC_CLK, 6: NOP cycles after each AUTO REFRESH
- BURST_REF, 2: AUTO REFRESH commands per debt unit
- MAX_DEBT, 8: debt saturation value
- URGENT_DEBT, 6: debt at which aref_urgent asserts
- ADDR_W, 13 / BA_W, 2: address and bank widths
- sys_clk  in  1  controller clock
- sys_rst  in  1  synchronous, active-high reset
- init_end  in  1  initialisation complete; timer runs only while high
- aref_en  in  1  arbiter grant; sampled only in IDLE
- aref_req  out  1  debt != 0 and state IDLE
- aref_urgent  out  1  debt >= URGENT_DEBT
- aref_cmd  out  4  {cs_n,ras_n,cas_n,we_n}, registered
- aref_ba  out  BA_W  all ones, registered
- aref_addr  out  ADDR_W  all ones (A10=1 precharge-all), registered
- aref_end  out  1  one-cycle service-complete pulse
- aref_busy  out  1  state != IDLE
- aref_debt  out  $clog2(MAX_DEBT+1)  outstanding refresh units
- aref_ovf  out  1  sticky: tick arrived with debt at MAX_DEBT

## Operation
- Reset values: aref_cmd=NOP (4'b0111), ba/addr all ones, req/urgent/end/busy/ovf=0, debt=0, timer=0, state IDLE.
- Timer: counts 0..REF_INTERVAL-1 while init_end=1 and wraps; tick is asserted on the cycle the count equals REF_INTERVAL-1. While init_end=0, the timer is held at 0.
- Debt update: tick increments debt. Completion of a refresh group (BURST_REF refreshes plus their tRC) decrements it. A tick and a decrement in the same cycle leave debt unchanged. A tick while debt=MAX_DEBT holds debt and sets aref_ovf, which clears only on reset.
- States: IDLE, PCHA, TRP, AREF, TRC, END.
  - IDLE→PCHA when aref_en & init_end & debt!=0.
  - PCHA→TRP.
  - TRP→AREF after TRP_CLK cycles.
  - AREF→TRC.
  - TRC→AREF after TRC_CLK cycles, unless the burst is complete and debt (after decrement) is 0, in which case TRC→END.
  - END→IDLE.
- A service drains all debt, including ticks that arrive during the service. Only one PRECHARGE is issued per service.
- aref_en while debt=0 or init_end=0 is ignored.
- init_end falling mid-service: the service completes normally; the timer clears.
- sys_rst mid-service: immediate return to reset values on the next edge.

## Timing
- aref_cmd mirrors the state one cycle later (registered).
- aref_en sampled high at edge k puts PRECHARGE on aref_cmd after edge k+1.
- PRECHARGE is held exactly 1 cycle, then exactly TRP_CLK NOP cycles, then AUTO REFRESH.
- Each AUTO REFRESH is held 1 cycle, then exactly TRC_CLK NOP cycles.
- aref_end is combinational from state END and coincides with the final tRC NOP cycle on aref_cmd.
- aref_req drops in the cycle the state leaves IDLE.

## Configuration
- AREF_POSTPONE_EN defined: full debt counter as described above.
- Not defined: MAX_DEBT is forced to 1, so debt is a single pending flag. aref_urgent equals aref_req. A tick while debt=1 sets aref_ovf. The aref_debt port keeps its parameterised width, with upper bits tied to 0.

## Structure
- Shared package sdram_pkg holds:
  - command encodings NOP, P_CHARGE, A_REF
  - the aref state encoding
  - the debt width function
- Sub-module sdram_ref_tick contains the interval timer, the debt counter, the ovf flag and the urgent compare. The top level holds the FSM, the wait counter and the command register.

## Test plan
- init_end=1, aref_en tied 1, defaults: PRECHARGE appears, then 2 NOP, then (AREF + 6 NOP)×2, aref_end pulses once, debt goes 1→0.
- aref_en held 0 for 6×1248 cycles: debt=6 and aref_urgent=1. Then grant: 12 AUTO REFRESH commands issued after 1 PRECHARGE.
- aref_en held 0 for 9 intervals: debt saturates at 8 and aref_ovf=1. A following service returns debt to 0; aref_ovf remains 1.
- Tick landing on the same cycle as a group decrement: debt unchanged and the service extends by one group.
- sys_rst asserted during TRC: next cycle aref_cmd=NOP, debt=0, busy=0, then normal restart. init_end=0: no aref_req ever.
- Build without AREF_POSTPONE_EN, two intervals with no grant: debt=1, aref_ovf=1, aref_urgent=aref_req.
